// File: rtl/multi_ch_clk_gen_if.sv
// Control/status bundle for multi_ch_clk_gen: run enables, restart, config writes,
// and the divided clock-enable outputs.
interface multi_ch_clk_gen_if #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 26,
  parameter int unsigned CH_W  = 4
);
  logic [N_CH-1:0]  en;
  logic             sync_restart;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic             cfg_err;

  modport master (
    output en, sync_restart, cfg_we, cfg_ch, cfg_half,
    input  clk_out, tick, cfg_err
  );

  modport slave (
    input  en, sync_restart, cfg_we, cfg_ch, cfg_half,
    output clk_out, tick, cfg_err
  );
endinterface

// File: rtl/multi_ch_clk_gen.sv
// N-channel programmable square-wave divider with shadowed half-period, per-channel
// enable, global phase-align restart and rising-edge tick strobes.
module multi_ch_clk_gen #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned CH_W         = 4,
  parameter int unsigned DEFAULT_HALF = 25000000
) (
  input  logic             clk_50MHz,
  input  logic             reset_button,
  multi_ch_clk_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] DefaultHalf = CNT_W'(DEFAULT_HALF);
  localparam logic [CH_W:0]    ChLimit     = (CH_W+1)'(N_CH);

  logic [CNT_W-1:0] ctr_q    [N_CH];
  logic [CNT_W-1:0] ctr_d    [N_CH];
  logic [CNT_W-1:0] active_q [N_CH];
  logic [CNT_W-1:0] active_d [N_CH];
  logic [CNT_W-1:0] shadow_q [N_CH];
  logic [CNT_W-1:0] shadow_d [N_CH];
  logic [N_CH-1:0]  clk_q, clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;

  logic             wr_ok;
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  run;
  logic [N_CH-1:0]  term;

  always_comb begin
    wr_ok     = bus.cfg_we && ({1'b0, bus.cfg_ch} < ChLimit);
    cfg_err_d = bus.cfg_we && !wr_ok;
    wr_hit    = '0;
    run       = '0;
    term      = '0;
    clk_d     = '0;
    tick_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i]   = wr_ok && (bus.cfg_ch == CH_W'(i));
      run[i]      = bus.en[i] && (active_q[i] != '0);
      term[i]     = run[i] && (ctr_q[i] == active_q[i] - CNT_W'(1));
      shadow_d[i] = wr_hit[i] ? bus.cfg_half : shadow_q[i];
      ctr_d[i]    = '0;
      active_d[i] = shadow_q[i];

      if (bus.sync_restart || !run[i]) begin
        // Stopped/restarted channels reload from the pre-write shadow.
        ctr_d[i]    = '0;
        active_d[i] = shadow_q[i];
      end else if (term[i]) begin
        // A write landing on the terminal cycle takes effect for the very next phase.
        ctr_d[i]    = '0;
        clk_d[i]    = ~clk_q[i];
        tick_d[i]   = ~clk_q[i];
        active_d[i] = wr_hit[i] ? bus.cfg_half : shadow_q[i];
      end else begin
        ctr_d[i]    = ctr_q[i] + CNT_W'(1);
        clk_d[i]    = clk_q[i];
        active_d[i] = active_q[i];
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset_button) begin
      for (int i = 0; i < N_CH; i++) begin
        ctr_q[i]    <= '0;
        active_q[i] <= DefaultHalf;
        shadow_q[i] <= DefaultHalf;
      end
      clk_q     <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.clk_out = clk_q;
  assign bus.tick    = tick_q;
  assign bus.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_multi_ch_clk_gen.sv
// Directed bench for multi_ch_clk_gen with a 3-cycle default half-period; every
// expected clk_out/tick/cfg_err value is hand-derived per edge after reset release.
module tb_multi_ch_clk_gen;

  localparam int unsigned NCh   = 4;
  localparam int unsigned CntW  = 8;
  localparam int unsigned ChW   = 4;

  logic clk;
  logic reset_button;
  int   cyc;
  int   checks;
  int   failures;

  multi_ch_clk_gen_if #(.N_CH(NCh), .CNT_W(CntW), .CH_W(ChW)) bus ();

  multi_ch_clk_gen #(
    .N_CH(NCh),
    .CNT_W(CntW),
    .CH_W(ChW),
    .DEFAULT_HALF(3)
  ) dut (
    .clk_50MHz(clk),
    .reset_button(reset_button),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then check clk_out and tick.
  task automatic st(input logic [3:0] c, input logic [3:0] t);
    step();
    chk($sformatf("clk_out@e%0d", cyc), 32'(bus.clk_out), 32'(c));
    chk($sformatf("tick@e%0d", cyc), 32'(bus.tick), 32'(t));
  endtask

  task automatic wr(input logic [ChW-1:0] ch, input logic [CntW-1:0] half);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = ch;
    bus.cfg_half = half;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    reset_button     = 1'b1;
    bus.en           = 4'hF;
    bus.sync_restart = 1'b0;
    bus.cfg_we       = 1'b0;
    bus.cfg_ch       = '0;
    bus.cfg_half     = '0;
    step();
    step();
    chk("reset_clk_out", 32'(bus.clk_out), 32'h0);
    chk("reset_tick", 32'(bus.tick), 32'h0);
    chk("reset_cfg_err", 32'(bus.cfg_err), 32'h0);
    reset_button = 1'b0;
    cyc = 0;

    // Default half-period 3: low 3, high 3, tick at edge 3.
    st(4'h0, 4'h0); st(4'h0, 4'h0); st(4'hF, 4'hF); st(4'hF, 4'h0);
    st(4'hF, 4'h0); st(4'h0, 4'h0); st(4'h0, 4'h0);

    // ch1 -> half 1 while at ctr=1; old phase completes, then toggles every cycle.
    wr(1, 1);
    st(4'h0, 4'h0);
    bus.cfg_we = 1'b0;
    st(4'hF, 4'hF); st(4'hD, 4'h0); st(4'hF, 4'h2); st(4'h0, 4'h0);
    st(4'h2, 4'h2); st(4'h0, 4'h0);

    // ch2 -> half 5 exactly on its terminal cycle (bypass), then invalid channel 7.
    wr(2, 5);
    st(4'hF, 4'hF);
    wr(7, 9);
    st(4'hD, 4'h0);
    chk("cfg_err_pulse", 32'(bus.cfg_err), 32'h1);
    bus.cfg_we = 1'b0;
    st(4'hF, 4'h2);
    chk("cfg_err_clear", 32'(bus.cfg_err), 32'h0);
    st(4'h4, 4'h0); st(4'h6, 4'h2); st(4'h0, 4'h0); st(4'hB, 4'hB);

    // Drop en[0] for 4 cycles while high; rise comes 3 edges after re-enable.
    bus.en = 4'hE;
    st(4'h8, 4'h0); st(4'hA, 4'h2); st(4'h0, 4'h0); st(4'h6, 4'h6);
    bus.en = 4'hF;
    st(4'h4, 4'h0); st(4'hE, 4'hA); st(4'hD, 4'h1);

    // ch3 -> half 0: finishes current phase then holds low; half 2 restarts it.
    wr(3, 0);
    st(4'hF, 4'h2);
    bus.cfg_we = 1'b0;
    st(4'h1, 4'h0); st(4'h2, 4'h2); st(4'h0, 4'h0); st(4'h2, 4'h2); st(4'h1, 4'h1);
    wr(3, 2);
    st(4'h7, 4'h6);
    bus.cfg_we = 1'b0;
    st(4'h5, 4'h0); st(4'h6, 4'h2); st(4'hC, 4'h8); st(4'hE, 4'h2); st(4'h1, 4'h1);

    // Bring ch1/ch2 to half 3 ahead of the restart.
    wr(1, 3);
    st(4'h3, 4'h2);
    wr(2, 3);
    st(4'hB, 4'h8);
    bus.cfg_we = 1'b0;
    st(4'hA, 4'h0);

    // Restart with a same-cycle write to ch3: ch3 keeps half 2 for one phase.
    bus.sync_restart = 1'b1;
    wr(3, 3);
    st(4'h0, 4'h0);
    bus.sync_restart = 1'b0;
    bus.cfg_we       = 1'b0;
    chk("restart_cfg_err", 32'(bus.cfg_err), 32'h0);
    st(4'h0, 4'h0); st(4'h8, 4'h8); st(4'hF, 4'h7); st(4'hF, 4'h0); st(4'h7, 4'h0);
    st(4'h0, 4'h0); st(4'h0, 4'h0); st(4'h8, 4'h8); st(4'hF, 4'h7);

    // Reset overrides restart and a write; default rate resumes.
    reset_button     = 1'b1;
    bus.sync_restart = 1'b1;
    wr(0, 7);
    st(4'h0, 4'h0);
    chk("reset_over_cfg_err", 32'(bus.cfg_err), 32'h0);
    reset_button     = 1'b0;
    bus.sync_restart = 1'b0;
    bus.cfg_we       = 1'b0;
    st(4'h0, 4'h0); st(4'h0, 4'h0); st(4'hF, 4'hF); st(4'hF, 4'h0);
    st(4'hF, 4'h0); st(4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_ch_clk_gen.md
Name: multi_ch_clk_gen

Overview:
- Parametrised successor to the fixed 50 MHz to 1 Hz divider.
- Provides N_CH independent square-wave clock-enable outputs plus single-cycle tick strobes.
- Each channel's half-period is programmable at runtime, with a shadow register for glitch-free rate changes, a per-channel enable, and a global phase-align restart.
- Sits beside the system clock input and feeds display refresh, blink, debounce and 1 Hz timekeeping logic.

Parameters:
- N_CH, 4, number of channels (1..16).
- CNT_W, 26, counter and half-period width. Must be at least 1.
- CH_W, 4, width of cfg_ch. Must satisfy 2^CH_W >= N_CH.
- DEFAULT_HALF, 25000000, half-period loaded into every channel at reset. 25000000 gives 1 Hz from 50 MHz.

Ports:
- clk_50MHz  in  1  system clock. All logic is on the rising edge.
- reset_button  in  1  synchronous, active-high reset.
- en  in  N_CH  per-channel run enable. Level-sensitive.
- sync_restart  in  1  single-cycle request: zero all counters and outputs together.
- cfg_we  in  1  configuration write strobe. One cycle per write.
- cfg_ch  in  CH_W  target channel index.
- cfg_half  in  CNT_W  new half-period, in clk_50MHz cycles.
- clk_out  out  N_CH  divided square waves, registered.
- tick  out  N_CH  one-cycle pulse on each rising edge of clk_out, registered.
- cfg_err  out  1  one-cycle pulse: last write targeted cfg_ch >= N_CH.

Behaviour:
- Clock and reset:
  - One clock domain, clk_50MHz.
  - Reset is synchronous and active-high, sampled on the rising edge of clk_50MHz.
- Per-channel state: ctr[CNT_W], active[CNT_W], shadow[CNT_W], clk_out, tick.
- Reset values:
  - ctr = 0.
  - active = shadow = DEFAULT_HALF.
  - clk_out = 0, tick = 0, cfg_err = 0.
- Priority each cycle: reset_button > sync_restart > per-channel logic.
- Terminal condition per channel: term = en & (active != 0) & (ctr == active - 1).
- Run (en=1, active!=0):
  - If term: ctr <= 0, clk_out <= ~clk_out, active <= shadow.
  - Otherwise: ctr <= ctr + 1.
  - Output period is 2*active cycles at 50% duty.
  - active = 1 toggles clk_out every cycle.
- Tick:
  - tick <= term & ~clk_out, so tick is high only in the cycle clk_out becomes 1.
  - At most one tick per 2*active cycles.
- Disabled (en=0): ctr <= 0, clk_out <= 0, tick <= 0, active <= shadow.
  - Re-enabling starts a full low half-period; the first rising edge comes active cycles after en rises.
- Zero half-period (active == 0): channel is stopped with outputs low, as if disabled. active <= shadow every cycle.
- Config write (cfg_we=1, cfg_ch < N_CH):
  - shadow[cfg_ch] <= cfg_half.
  - The new value reaches active at the next terminal event, or on the next cycle if that channel is disabled or stopped.
  - The current half-period always completes at its old length; no truncated or stretched phases.
- Simultaneous write and terminal on the same channel: cfg_half bypasses shadow, so active <= cfg_half directly. The new rate applies from the very next half-period.
- Invalid write (cfg_we=1, cfg_ch >= N_CH): no state changes; cfg_err <= 1 for one cycle. Otherwise cfg_err <= 0.
- sync_restart:
  - All channels: ctr <= 0, clk_out <= 0, tick <= 0, active <= shadow.
  - A cfg write in the same cycle still updates shadow, but active takes the pre-write shadow.
  - After release, all enabled channels with equal active values are phase-identical.
- Reset mid-operation: all state returns to reset values on the next edge, overriding any write or restart.
- Arithmetic: the counter never exceeds active-1. Lowering active through the shadow cannot cause an overshoot, because active only changes at terminal or while stopped.
- Latency: clk_out and tick are registered, one cycle after the terminal count; no combinational paths from inputs to outputs.

Test Plan:
- Reset default (DEFAULT_HALF overridden to 3, en=all 1) -> every clk_out is low 3 cycles then high 3 cycles (period 6). tick is high exactly on cycles 3, 9, 15… after reset release.
- Write ch1 cfg_half=1 mid-phase, with ch1 at ctr=1 of 3 -> current half-phase ends at 3 cycles, then ch1 toggles every cycle. Other channels are unchanged.
- Write ch2 cfg_half=5 on the exact cycle ch2 hits terminal -> next ch2 half-period is 5 cycles (bypass). cfg_ch=7 with N_CH=4 -> cfg_err pulses once and no shadow changes.
- Drop en[0] for 4 cycles while clk_out[0]=1 -> clk_out[0]=0 next cycle. After re-enable, the rise comes exactly 3 cycles later with tick.
- Write cfg_half=0 to ch3 -> ch3 holds low after its current phase. Writing 2 then restarts it within one cycle with period 4.
- Channels at different phases, assert sync_restart for 1 cycle -> all clk_out go 0 next cycle and subsequently toggle in lockstep. Asserting reset_button together with sync_restart yields reset values only.
